// File: rtl/onex4demux_buf.sv
// ---------------------------------------------------------------------------
// onex4demux_buf
//   Registered 1-to-4 stream demultiplexer with valid/ready handshaking.
//   Each accepted input word is steered by `sel` into a one-entry buffer on
//   one of four output channels. The word stays there until that channel's
//   consumer takes it. Every channel keeps its own delivered-word counter,
//   and `cnt_sel` picks which counter appears on `cnt`.
//
// Ports
//   clk       : system clock, rising-edge active
//   rst_n     : asynchronous active-low reset
//   a         : input data word
//   sel       : destination channel for `a` (0..3)
//   a_valid   : `a`/`sel` valid
//   a_ready   : block can accept `a` this cycle
//   y0..y3    : channel data, driven straight from the buffer registers
//   y_valid   : bit k = channel k buffer holds a word
//   y_ready   : bit k = channel k consumer accepts
//   cnt_clr   : synchronous clear of all delivery counters
//   cnt_sel   : selects the counter shown on `cnt`
//   cnt       : delivery count of channel `cnt_sel`
//   idle      : all four buffers empty
// ---------------------------------------------------------------------------
module onex4demux_buf #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [1:0]            sel,
  input  logic                  a_valid,
  output logic                  a_ready,
  output logic [DATA_WIDTH-1:0] y0,
  output logic [DATA_WIDTH-1:0] y1,
  output logic [DATA_WIDTH-1:0] y2,
  output logic [DATA_WIDTH-1:0] y3,
  output logic [3:0]            y_valid,
  input  logic [3:0]            y_ready,
  input  logic                  cnt_clr,
  input  logic [1:0]            cnt_sel,
  output logic [CNT_WIDTH-1:0]  cnt,
  output logic                  idle
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [DATA_WIDTH-1:0] r_dat [4];
  logic [3:0]            r_vld;
  logic [CNT_WIDTH-1:0]  r_cnt [4];

  logic                  w_acc;
  logic [3:0]            w_xfer;

  // The addressed buffer can take a word when it is empty, or when it is
  // draining this same cycle. This gives one word per clock per channel.
  // The result does not depend on a_valid.
  assign a_ready = ~r_vld[sel] | y_ready[sel];
  assign w_acc   = a_valid & a_ready;
  assign w_xfer  = r_vld & y_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int k = 0; k < 4; k++) begin
        r_dat[k] <= '0;
        r_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        // A load takes priority over a drain. When both happen in the same
        // cycle, the old word leaves and the new word replaces it, so the
        // valid bit stays set.
        if (w_acc && (sel == 2'(k))) begin
          r_dat[k] <= a;
          r_vld[k] <= 1'b1;
        end else if (w_xfer[k]) begin
          r_vld[k] <= 1'b0;
        end

        // A clear overrides a transfer in the same cycle, so that transfer
        // is not counted. The counter wraps naturally.
        if (cnt_clr) begin
          r_cnt[k] <= '0;
        end else if (w_xfer[k]) begin
          r_cnt[k] <= r_cnt[k] + CNT_ONE;
        end
      end
    end
  end

  assign y0      = r_dat[0];
  assign y1      = r_dat[1];
  assign y2      = r_dat[2];
  assign y3      = r_dat[3];
  assign y_valid = r_vld;
  assign cnt     = r_cnt[cnt_sel];
  assign idle    = ~|r_vld;

endmodule

// File: doc/onex4demux_buf.md
Name: onex4demux_buf

Overview:
- Registered 1-to-4 stream demultiplexer with valid/ready handshaking. It is the distribution-side counterpart of the 4-way data selector.
- Routes each accepted input word to one of four output channels, chosen by `sel`.
- Each channel holds its word in a one-entry buffer until its consumer accepts it.
- Keeps a per-channel delivered-word counter, readable through a 2-bit count select.

Parameters:
- DATA_WIDTH, 4, width of data words.
- CNT_WIDTH, 8, width of each per-channel delivery counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  reset; asynchronous, active-low
- a  input  DATA_WIDTH  input data word
- sel  input  2  destination channel for `a` (0..3)
- a_valid  input  1  `a`/`sel` valid
- a_ready  output  1  block can accept `a` this cycle
- y0, y1, y2, y3  output  DATA_WIDTH each  channel data, from the channel buffer register
- y_valid  output  4  bit k = channel k buffer holds a word
- y_ready  input  4  bit k = channel k consumer accepts
- cnt_clr  input  1  synchronous clear of all counters
- cnt_sel  input  2  counter to present on `cnt`
- cnt  output  CNT_WIDTH  delivery count of channel `cnt_sel`
- idle  output  1  all four buffers empty

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - y_valid=4'b0000, y0..y3=0, all counters=0.
  - a_ready=1 and idle=1 while rst_n=0 and after release.
  - Words in flight are discarded; no partial state survives.
- Handshakes:
  - In-accept = a_valid & a_ready.
  - Out-transfer k = y_valid[k] & y_ready[k].
  - a_ready = ~y_valid[sel] | y_ready[sel]. It is combinational on sel/y_valid/y_ready and does not depend on a_valid.
  - Channel k can therefore take a new word in the same cycle its held word drains (full throughput, one word per clock).
- Channel k buffer, evaluated each rising edge:
  - in-accept with sel==k: load yk<=a, y_valid[k]<=1. This holds whether or not transfer k also occurs that cycle.
  - else transfer k: y_valid[k]<=0; yk holds its last value.
  - else: no change.
- Latency: a word accepted at edge N is visible on yk with y_valid[k]=1 after edge N, i.e. 1 cycle.
- Data stability: while y_valid[k]=1 and y_ready[k]=0, yk and y_valid[k] must not change.
- Channel independence:
  - Channels drain independently; a stalled channel blocks only input words addressed to it.
  - Ordering is preserved per channel only; there is no ordering across channels.
- No input buffering: when a_ready=0 the source must hold a/sel/a_valid stable. The block does not capture anything in that case.
- Counters:
  - cnt_k increments by 1 on each out-transfer k.
  - Wraps from 2^CNT_WIDTH-1 to 0; no saturation, no flag.
  - cnt_clr=1 sets all counters to 0 on that edge. cnt_clr wins over a simultaneous transfer, so that transfer is not counted.
- cnt = cnt_{cnt_sel}, combinational selection of the counter registers.
- idle = ~|y_valid, combinational from registers.
- Simultaneous events:
  - Several channels may transfer in one cycle; each counter updates independently.
  - In-accept to channel k while other channels transfer is legal.
- Implementation: y_ready values are don't-care when the matching y_valid bit is 0.

Test Plan:
- Reset release, then a=4'hA, sel=2, a_valid=1 for 1 cycle, y_ready=4'b1111:
  - y_valid=4'b0100 and y2=4'hA one cycle after accept, cleared the next cycle.
  - cnt_sel=2 gives cnt=1; idle returns to 1.
- Backpressure, y_ready[1]=0:
  - Send 4'h3 then 4'h5 to sel=1: first is accepted; a_ready=0 with sel=1 and y1 holds 4'h3.
  - Raise y_ready[1]: on the next edge 4'h3 is delivered and 4'h5 is loaded in the same cycle, with y_valid[1] staying 1.
- Independence:
  - Channel 0 stalled holding 4'h1.
  - Words 4'h7→sel3 and 4'h8→sel2 are each accepted in 1 cycle.
  - a_ready goes low only when sel=0 is presented.
- Streaming: 16 back-to-back words 0..F with sel=i%4, all ready.
  - One accept per cycle; each channel sees its words in order (ch0: 0,4,8,C).
  - Each cnt=4.
- Counter wrap/clear, CNT_WIDTH=8:
  - 256 transfers on ch0 give cnt=0 with cnt_sel=0.
  - cnt_clr asserted in the same cycle as a ch0 transfer gives cnt=0, not 1.
- Asynchronous reset mid-operation:
  - Assert rst_n=0 between edges while y_valid=4'b1011 and counters are nonzero.
  - Outputs go to y_valid=0, y0..y3=0, cnt=0, idle=1 immediately, before the next clock edge.
